csa_tree_pipe: RTL and testbench
================================

Name: csa_tree_pipe

Overview:
- Parametrised, pipelined multi-operand carry-save reduction tree built from 4:2 compressor levels.
- Reduces NUM_OPERANDS packed operands to one redundant sum/carry pair, with a register stage after every level and valid/ready flow control.
- Successor to the single-level combinational 4:2 array: adds operand-count generalisation, pipelining, back-pressure and an optional final carry-propagate adder.
- Sits between the Booth partial-product generator and the multiplier's final adder.

Parameters:
- WIDTH, 32, operand and result width in bits.
- NUM_OPERANDS, 8, number of input operands; must be a power of two and at least 4.
- TAG_WIDTH, 4, width of the sideband tag carried alongside each transaction.
- LEVELS, log2(NUM_OPERANDS)-1, derived: number of 4:2 levels; must not be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input transaction valid.
- in_ready  output  1  block can accept a transaction this cycle.
- in_ops  input  NUM_OPERANDS*WIDTH  packed operands; operand k occupies bits [k*WIDTH +: WIDTH].
- in_tag  input  TAG_WIDTH  sideband tag, passed through unchanged.
- out_valid  output  1  output transaction valid.
- out_ready  input  1  downstream accepts the output.
- out_sum  output  WIDTH  redundant sum vector.
- out_carry  output  WIDTH  redundant carry vector; bit i has weight 2^(i+1).
- out_tag  output  TAG_WIDTH  tag of the transaction on the output.
- out_result  output  WIDTH  resolved result; present only with CSA_TREE_CPA_EN.

Behaviour:
- Level j reduces NUM_OPERANDS/2^j vectors to half as many by applying 4:2 groups.
  - Group g at level j consumes vectors 4g..4g+3 of that level.
  - Each group produces sum and (carry<<1) as two new vectors.
- 4:2 cell per bit:
  - eout = maj(x1,x2,x3).
  - sum = x0^x1^x2^x3^ein.
  - cout = x0 when (x0^x1^x2^x3)=0, else ein.
  - ein of bit 0 = 0.
  - eout of bit WIDTH-1 and cout of bit WIDTH-1 are dropped.
- Arithmetic contract: (out_sum + (out_carry<<1)) mod 2^WIDTH == (sum of all operands) mod 2^WIDTH.
- Pipeline register after every level; each stage holds a valid bit, its data and the tag.
- Latency: LEVELS cycles from input acceptance to out_valid when not stalled (NUM_OPERANDS=8: 2 cycles). Add 1 cycle with CSA_TREE_CPA_EN.
- Throughput: one transaction per cycle when out_ready is held high.
- Stage advance rule: stage s loads from s-1 when stage s is empty or stage s is being drained in the same cycle.
- in_ready = ~v[0] | advance[0]. in_ready is combinational from out_ready through the stall chain.
- Transfer on the input side only when in_valid & in_ready; in_ops and in_tag are sampled on that edge only.
- While out_valid & ~out_ready: out_sum, out_carry, out_tag and out_result hold stable; no transaction is dropped or duplicated.
- A full pipeline with out_ready low deasserts in_ready. Accepted-but-undelivered transactions number at most the stage count.
- Simultaneous drain and fill of a full pipeline in one cycle keeps it full with no bubble.
- Reset, including mid-operation:
  - All valid bits go to 0, so out_valid = 0.
  - out_sum, out_carry, out_tag and out_result go to 0.
  - In-flight transactions are discarded.
  - in_ready = 1 in the first cycle after reset deasserts.
- Tags are never reordered; output order equals input order.

Optional Feature:
- Macro: CSA_TREE_CPA_EN.
- Defined:
  - Adds one extra registered stage computing out_result = (sum + (carry<<1)) mod 2^WIDTH.
  - out_sum and out_carry remain valid and aligned with out_result.
  - Latency is LEVELS+1.
- Undefined:
  - out_result port is absent.
  - Latency is LEVELS.

Test Plan:
- Reset then 8 operands each 32'h1, tag 4'h3, out_ready=1: out_valid after 2 cycles; sum+(carry<<1)=8; out_tag=3; out_result=8 when CPA enabled.
- Overflow: 8 operands 32'hFFFF_FFFF -> redundant pair resolves to 32'hFFFF_FFF8.
- Streaming 100 random 8-operand vectors, out_ready=1: one output per cycle, in order, all sums match the model.
- out_ready low for 5 cycles while driving continuously: in_ready falls once 2 stages are full (3 with CPA); outputs are stable; after release, no loss or duplication.
- rst_n low for one cycle with 2 transactions in flight: out_valid=0 next cycle; neither transaction appears; a new transaction completes normally.
- NUM_OPERANDS=4 and 16, WIDTH=8: latency 1 and 3 respectively; random sums mod 256 correct.

Source files
------------

// File: rtl/csa_tree_pipe.sv
// Pipelined 4:2 carry-save reduction tree, one register stage per level, valid/ready stall chain.
// CSA_TREE_CPA_EN adds one registered carry-propagate stage driving out_result (latency LEVELS+1).
module csa_tree_pipe #(
  parameter int WIDTH        = 32,
  parameter int NUM_OPERANDS = 8,
  parameter int TAG_WIDTH    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_OPERANDS*WIDTH-1:0] in_ops,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_sum,
  output logic [WIDTH-1:0]              out_carry,
`ifdef CSA_TREE_CPA_EN
  output logic [WIDTH-1:0]              out_result,
`endif
  output logic [TAG_WIDTH-1:0]          out_tag
);

  localparam int LEVELS = $clog2(NUM_OPERANDS) - 1;
`ifdef CSA_TREE_CPA_EN
  localparam int NSTG = LEVELS + 1;
`else
  localparam int NSTG = LEVELS;
`endif
  // All level outputs live in one flat array: level l writes NUM_OPERANDS>>(l+1) vectors.
  localparam int NVEC = NUM_OPERANDS - 2;
  localparam int NSRC = NUM_OPERANDS + NVEC;

  function automatic int dst_off(input int l);
    return NUM_OPERANDS - (NUM_OPERANDS >> l);
  endfunction

  // Source index space is {input operands, flat level outputs}, so level 0 needs no special case.
  function automatic int src_off(input int l);
    return 2 * NUM_OPERANDS - 2 * (NUM_OPERANDS >> l);
  endfunction

  // Returns {carry<<1, sum}; the MSB carry and MSB horizontal carry fall off the top.
  function automatic logic [2*WIDTH-1:0] cmp42(input logic [WIDTH-1:0] x0, input logic [WIDTH-1:0] x1,
                                               input logic [WIDTH-1:0] x2, input logic [WIDTH-1:0] x3);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] csh;
    logic             ein;
    logic             p;
    ein = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      p    = x0[i] ^ x1[i] ^ x2[i] ^ x3[i];
      s[i] = p ^ ein;
      c[i] = p ? ein : x0[i];
      ein  = (x1[i] & x2[i]) | (x1[i] & x3[i]) | (x2[i] & x3[i]);
    end
    csh = c << 1;
    return {csh, s};
  endfunction

  logic [NSTG-1:0]      v_q;
  logic [NSTG-1:0]      v_d;
  logic [NSTG-1:0]      ld;
  logic [NSTG-1:0]      ldv;
  logic [TAG_WIDTH-1:0] tag_q [NSTG];
  logic [TAG_WIDTH-1:0] tag_d [NSTG];
  logic [WIDTH-1:0]     vec_q [NVEC];
  logic [WIDTH-1:0]     vec_d [NVEC];

  // A stage may load when out_ready is high or any stage from it to the output is empty.
  always_comb begin
    logic                 full;
    logic                 prev_v;
    logic [TAG_WIDTH-1:0] prev_tag;
    full = 1'b1;
    for (int s = NSTG - 1; s >= 0; s--) begin
      full  = full & v_q[s];
      ld[s] = out_ready | ~full;
    end
    prev_v   = in_valid;
    prev_tag = in_tag;
    for (int s = 0; s < NSTG; s++) begin
      ldv[s]   = ld[s] & prev_v;
      v_d[s]   = ld[s] ? prev_v : v_q[s];
      tag_d[s] = ldv[s] ? prev_tag : tag_q[s];
      prev_v   = v_q[s];
      prev_tag = tag_q[s];
    end
  end

  always_comb begin
    logic [WIDTH-1:0]   src [NSRC];
    logic [2*WIDTH-1:0] r;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      src[k] = in_ops[k*WIDTH +: WIDTH];
    end
    for (int k = 0; k < NVEC; k++) begin
      src[NUM_OPERANDS + k] = vec_q[k];
      vec_d[k]              = vec_q[k];
    end
    for (int l = 0; l < LEVELS; l++) begin
      for (int g = 0; g < (NUM_OPERANDS >> (l + 2)); g++) begin
        r = cmp42(src[src_off(l) + 4*g], src[src_off(l) + 4*g + 1],
                  src[src_off(l) + 4*g + 2], src[src_off(l) + 4*g + 3]);
        if (ldv[l]) begin
          vec_d[dst_off(l) + 2*g]     = r[WIDTH-1:0];
          vec_d[dst_off(l) + 2*g + 1] = r[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < NSTG; s++) tag_q[s] <= '0;
      for (int k = 0; k < NVEC; k++) vec_q[k] <= '0;
    end else begin
      v_q <= v_d;
      for (int s = 0; s < NSTG; s++) tag_q[s] <= tag_d[s];
      for (int k = 0; k < NVEC; k++) vec_q[k] <= vec_d[k];
    end
  end

`ifdef CSA_TREE_CPA_EN
  logic [WIDTH-1:0] fsum_q;
  logic [WIDTH-1:0] fsum_d;
  logic [WIDTH-1:0] fcar_q;
  logic [WIDTH-1:0] fcar_d;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;

  always_comb begin
    fsum_d = fsum_q;
    fcar_d = fcar_q;
    res_d  = res_q;
    if (ldv[LEVELS]) begin
      fsum_d = vec_q[NVEC-2];
      fcar_d = vec_q[NVEC-1];
      res_d  = vec_q[NVEC-2] + vec_q[NVEC-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsum_q <= '0;
      fcar_q <= '0;
      res_q  <= '0;
    end else begin
      fsum_q <= fsum_d;
      fcar_q <= fcar_d;
      res_q  <= res_d;
    end
  end

  assign out_sum    = fsum_q;
  assign out_carry  = fcar_q >> 1;
  assign out_result = res_q;
`else
  // The stored carry vector is pre-shifted; the port carries the unshifted form.
  assign out_sum   = vec_q[NVEC-2];
  assign out_carry = vec_q[NVEC-1] >> 1;
`endif

  assign in_ready  = ld[0];
  assign out_valid = v_q[NSTG-1];
  assign out_tag   = tag_q[NSTG-1];

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Bench for csa_tree_pipe: directed and random transactions against a queue-based sum model.
module tb_csa_tree_pipe;
  localparam int W  = 32;
  localparam int N  = 8;
  localparam int TW = 4;
`ifdef CSA_TREE_CPA_EN
  localparam int CPA = 1;
`else
  localparam int CPA = 0;
`endif
  localparam int LAT   = 2 + CPA;
  localparam int LAT4  = 1 + CPA;
  localparam int LAT16 = 3 + CPA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N*W-1:0] in_ops;
  logic [TW-1:0] in_tag, out_tag;
  logic [W-1:0]  out_sum, out_carry;
`ifdef CSA_TREE_CPA_EN
  logic [W-1:0]  out_result;
`endif

  logic          s_vld, s_rdy, s4_rdy, s16_rdy, s4_ov, s16_ov;
  logic [31:0]   s4_ops;
  logic [127:0]  s16_ops;
  logic [7:0]    s4_sum, s4_car, s16_sum, s16_car;
  logic [TW-1:0] s4_tag, s16_tag;
`ifdef CSA_TREE_CPA_EN
  logic [7:0]    s4_res, s16_res;
`endif

  csa_tree_pipe #(.WIDTH(W), .NUM_OPERANDS(N), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef CSA_TREE_CPA_EN
    .out_result(out_result),
`endif
    .out_carry(out_carry), .out_tag(out_tag));

  csa_tree_pipe #(.WIDTH(8), .NUM_OPERANDS(4), .TAG_WIDTH(TW)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_ready(s4_rdy), .in_ops(s4_ops),
    .in_tag(4'h0), .out_valid(s4_ov), .out_ready(s_rdy), .out_sum(s4_sum),
`ifdef CSA_TREE_CPA_EN
    .out_result(s4_res),
`endif
    .out_carry(s4_car), .out_tag(s4_tag));

  csa_tree_pipe #(.WIDTH(8), .NUM_OPERANDS(16), .TAG_WIDTH(TW)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_vld), .in_ready(s16_rdy), .in_ops(s16_ops),
    .in_tag(4'h0), .out_valid(s16_ov), .out_ready(s_rdy), .out_sum(s16_sum),
`ifdef CSA_TREE_CPA_EN
    .out_result(s16_res),
`endif
    .out_carry(s16_car), .out_tag(s16_tag));

  int           total = 0;
  int           bad   = 0;
  int           n_out = 0;
  logic [W-1:0]  q_sum [$];
  logic [TW-1:0] q_tag [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_sum(input logic [N*W-1:0] ops);
    logic [W-1:0] acc = '0;
    for (int k = 0; k < N; k++) acc += ops[k*W +: W];
    return acc;
  endfunction

  function automatic logic [7:0] ref_sum8(input logic [127:0] ops, input int n);
    logic [7:0] acc = '0;
    for (int k = 0; k < n; k++) acc += ops[k*8 +: 8];
    return acc;
  endfunction

  task automatic rand_in();
    for (int k = 0; k < N; k++) in_ops[k*W +: W] = $urandom();
    in_tag = 4'($urandom_range(15, 0));
  endtask

  // One clock: record handshakes mid-cycle, score outputs, then step past the edge.
  task automatic cycle();
    logic [W-1:0] r;
    @(negedge clk);
    if (in_valid && in_ready) begin
      q_sum.push_back(ref_sum(in_ops));
      q_tag.push_back(in_tag);
    end
    if (out_valid && out_ready) begin
      chk("out_expected", q_sum.size() != 0, 1'b1);
      if (q_sum.size() != 0) begin
        r = out_sum + (out_carry << 1);
        chk("stream_sum", r, q_sum[0]);
        chk("stream_tag", out_tag, q_tag[0]);
`ifdef CSA_TREE_CPA_EN
        chk("result", out_result, q_sum[0]);
`endif
        void'(q_sum.pop_front());
        void'(q_tag.pop_front());
        n_out++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && q_sum.size() != 0; i++) cycle();
    chk("drain_empty", q_sum.size(), 0);
  endtask

  task automatic single(input logic [N*W-1:0] ops, input logic [TW-1:0] tag,
                        input logic [W-1:0] direct, input string nm);
    logic [W-1:0] r;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ops    = ops;
    in_tag    = tag;
    cycle();
    in_valid = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      chk({nm, "_vld"}, out_valid, k == LAT);
      if (k == LAT) begin
        r = out_sum + (out_carry << 1);
        chk(nm, r, direct);
        chk({nm, "_tag"}, out_tag, tag);
`ifdef CSA_TREE_CPA_EN
        chk({nm, "_res"}, out_result, direct);
`endif
      end
      cycle();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] ops;
    logic [W-1:0]   r;
    logic [7:0]     r8, e4, e16;
    int             base;
    rst_n = 1'b0; in_valid = 1'b0; in_ops = '0; in_tag = '0; out_ready = 1'b1;
    s_vld = 1'b0; s_rdy = 1'b1; s4_ops = '0; s16_ops = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_carry", out_carry, 0);
    chk("rst_out_tag", out_tag, 0);

    for (int k = 0; k < N; k++) ops[k*W +: W] = 32'h1;
    single(ops, 4'h3, 32'h8, "ones");
    ops = '1;
    single(ops, 4'hA, 32'hFFFF_FFF8, "overflow");

    // Back-to-back streaming
    base = n_out;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      rand_in();
      #1;
      chk("stream_rdy", in_ready, 1'b1);
      if (i >= LAT) chk("stream_vld", out_valid, 1'b1);
      cycle();
    end
    drain();
    chk("stream_count", n_out - base, 100);

    // Output stall with continuous input
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rand_in();
      #1;
      chk("stall_rdy", in_ready, q_sum.size() < LAT);
      if (out_valid && q_sum.size() != 0) begin
        r = out_sum + (out_carry << 1);
        chk("hold_sum", r, q_sum[0]);
        chk("hold_tag", out_tag, q_tag[0]);
      end
      cycle();
    end
    chk("stall_full", q_sum.size(), LAT);
    chk("stall_vld", out_valid, 1'b1);
    base = n_out;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      rand_in();
      cycle();
    end
    drain();
    chk("release_count", n_out - base, LAT + 5);

    // Reset with two transactions in flight
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      rand_in();
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q_sum.delete();
    q_tag.delete();
    chk("midrst_vld", out_valid, 1'b0);
    chk("midrst_rdy", in_ready, 1'b1);
    chk("midrst_sum", out_sum, 0);
    chk("midrst_tag", out_tag, 0);
    out_ready = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      chk("no_ghost", out_valid, 1'b0);
      cycle();
    end
    for (int k = 0; k < N; k++) ops[k*W +: W] = $urandom();
    single(ops, 4'h5, ref_sum(ops), "post_rst");

    // Narrow 4- and 16-operand instances
    for (int it = 0; it < 4; it++) begin
      s4_ops  = $urandom();
      s16_ops = {$urandom(), $urandom(), $urandom(), $urandom()};
      e4  = ref_sum8({96'h0, s4_ops}, 4);
      e16 = ref_sum8(s16_ops, 16);
      s_vld = 1'b1;
      @(posedge clk);
      #1;
      s_vld = 1'b0;
      for (int k = 1; k <= LAT16; k++) begin
        chk("n4_vld", s4_ov, k == LAT4);
        chk("n16_vld", s16_ov, k == LAT16);
        if (k == LAT4) begin
          r8 = s4_sum + (s4_car << 1);
          chk("n4_sum", r8, e4);
`ifdef CSA_TREE_CPA_EN
          chk("n4_res", s4_res, e4);
`endif
        end
        if (k == LAT16) begin
          r8 = s16_sum + (s16_car << 1);
          chk("n16_sum", r8, e16);
`ifdef CSA_TREE_CPA_EN
          chk("n16_res", s16_res, e16);
`endif
        end
        @(posedge clk);
        #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
